// File: rtl/uart_rx_cmd_fsm.sv
// 8N1 UART receiver with a 5-byte command packet decoder (header, id, lo, hi, xor checksum).
// Emits checksum-verified commands as one-cycle strobes; aborted packets raise cmd_err with a cause code.
module uart_rx_cmd_fsm #(
   parameter int unsigned CLKS_PER_BIT = 1085,
   parameter int unsigned TIMEOUT_CLKS = 125000,
   parameter logic [7:0]  HEADER       = 8'hA5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        serial_rx,
   output logic        byte_valid,
   output logic [7:0]  byte_data,
   output logic        cmd_valid,
   output logic [7:0]  cmd_id,
   output logic [15:0] cmd_data,
   output logic        cmd_err,
   output logic [1:0]  err_code
);

   localparam logic [15:0] HALF_LAST = 16'((CLKS_PER_BIT - 1) / 2 - 1);
   localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
   localparam logic [16:0] TMO_LIMIT = 17'(TIMEOUT_CLKS);

   typedef enum logic [2:0] {B_IDLE, B_START, B_DATA, B_STOP, B_BREAK} bit_state_t;
   typedef enum logic [2:0] {P_HDR, P_ID, P_LO, P_HI, P_CHK} pkt_state_t;

   logic        sync1_q, rx_s_q;
   bit_state_t  bit_state_q, bit_state_d;
   logic [15:0] clk_cnt_q, clk_cnt_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [7:0]  shift_q, shift_d;
   logic        byte_valid_q, byte_valid_d;
   logic [7:0]  byte_data_q, byte_data_d;
   logic        frame_err;

   pkt_state_t  pkt_state_q, pkt_state_d;
   logic [7:0]  id_q, id_d, lo_q, lo_d, hi_q, hi_d;
   logic        cmd_valid_q, cmd_valid_d;
   logic [7:0]  cmd_id_q, cmd_id_d;
   logic [15:0] cmd_data_q, cmd_data_d;
   logic        cmd_err_q, cmd_err_d;
   logic [1:0]  err_code_q, err_code_d;
   logic [16:0] tmo_cnt_q, tmo_cnt_d;

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_q      <= 1'b1;
         rx_s_q       <= 1'b1;
         bit_state_q  <= B_IDLE;
         clk_cnt_q    <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         byte_valid_q <= 1'b0;
         byte_data_q  <= '0;
         pkt_state_q  <= P_HDR;
         id_q         <= '0;
         lo_q         <= '0;
         hi_q         <= '0;
         cmd_valid_q  <= 1'b0;
         cmd_id_q     <= '0;
         cmd_data_q   <= '0;
         cmd_err_q    <= 1'b0;
         err_code_q   <= '0;
         tmo_cnt_q    <= '0;
      end else begin
         sync1_q      <= serial_rx;
         rx_s_q       <= sync1_q;
         bit_state_q  <= bit_state_d;
         clk_cnt_q    <= clk_cnt_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         byte_valid_q <= byte_valid_d;
         byte_data_q  <= byte_data_d;
         pkt_state_q  <= pkt_state_d;
         id_q         <= id_d;
         lo_q         <= lo_d;
         hi_q         <= hi_d;
         cmd_valid_q  <= cmd_valid_d;
         cmd_id_q     <= cmd_id_d;
         cmd_data_q   <= cmd_data_d;
         cmd_err_q    <= cmd_err_d;
         err_code_q   <= err_code_d;
         tmo_cnt_q    <= tmo_cnt_d;
      end
   end

   always_comb begin
      bit_state_d  = bit_state_q;
      clk_cnt_d    = clk_cnt_q + 16'd1;
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      byte_valid_d = 1'b0;
      byte_data_d  = byte_data_q;
      frame_err    = 1'b0;
      case (bit_state_q)
         B_IDLE: begin
            clk_cnt_d = '0;
            if (!rx_s_q) bit_state_d = B_START;
         end
         B_START: begin
            if (clk_cnt_q == HALF_LAST) begin
               clk_cnt_d   = '0;
               bit_idx_d   = '0;
               bit_state_d = rx_s_q ? B_IDLE : B_DATA;
            end
         end
         B_DATA: begin
            if (clk_cnt_q == BIT_LAST) begin
               clk_cnt_d = '0;
               shift_d   = {rx_s_q, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) bit_state_d = B_STOP;
            end
         end
         B_STOP: begin
            if (clk_cnt_q == BIT_LAST) begin
               clk_cnt_d = '0;
               if (rx_s_q) begin
                  byte_valid_d = 1'b1;
                  byte_data_d  = shift_q;
                  bit_state_d  = B_IDLE;
               end else begin
                  frame_err   = 1'b1;
                  bit_state_d = B_BREAK;
               end
            end
         end
         B_BREAK: begin
            clk_cnt_d = '0;
            if (rx_s_q) bit_state_d = B_IDLE;
         end
         default: bit_state_d = B_IDLE;
      endcase
   end

   always_comb begin
      pkt_state_d = pkt_state_q;
      id_d        = id_q;
      lo_d        = lo_q;
      hi_d        = hi_q;
      cmd_valid_d = 1'b0;
      cmd_id_d    = cmd_id_q;
      cmd_data_d  = cmd_data_q;
      cmd_err_d   = 1'b0;
      err_code_d  = err_code_q;
      // The byte_valid cycle counts as the first idle cycle, so the abort
      // strobe lands TIMEOUT_CLKS cycles after the last byte strobe.
      tmo_cnt_d   = byte_valid_q ? 17'd1 : tmo_cnt_q + 17'd1;
      if (byte_valid_q) begin
         case (pkt_state_q)
            P_HDR: if (byte_data_q == HEADER) pkt_state_d = P_ID;
            P_ID: begin
               id_d        = byte_data_q;
               pkt_state_d = P_LO;
            end
            P_LO: begin
               lo_d        = byte_data_q;
               pkt_state_d = P_HI;
            end
            P_HI: begin
               hi_d        = byte_data_q;
               pkt_state_d = P_CHK;
            end
            P_CHK: begin
               if (byte_data_q == (id_q ^ lo_q ^ hi_q)) begin
                  cmd_valid_d = 1'b1;
                  cmd_id_d    = id_q;
                  cmd_data_d  = {hi_q, lo_q};
               end else begin
                  cmd_err_d  = 1'b1;
                  err_code_d = 2'd1;
               end
               pkt_state_d = P_HDR;
            end
            default: pkt_state_d = P_HDR;
         endcase
      end else if (pkt_state_q != P_HDR) begin
         if (frame_err) begin
            cmd_err_d   = 1'b1;
            err_code_d  = 2'd2;
            pkt_state_d = P_HDR;
         end else if (tmo_cnt_d == TMO_LIMIT) begin
            cmd_err_d   = 1'b1;
            err_code_d  = 2'd3;
            pkt_state_d = P_HDR;
         end
      end
      if (pkt_state_d == P_HDR) tmo_cnt_d = '0;
   end

   assign byte_valid = byte_valid_q;
   assign byte_data  = byte_data_q;
   assign cmd_valid  = cmd_valid_q;
   assign cmd_id     = cmd_id_q;
   assign cmd_data   = cmd_data_q;
   assign cmd_err    = cmd_err_q;
   assign err_code   = err_code_q;

endmodule

// File: tb/tb_uart_rx_cmd_fsm.sv
// Scoreboard bench for uart_rx_cmd_fsm: stimulus pushes expected bytes/commands, a negedge monitor pops and compares.
module tb_uart_rx_cmd_fsm;

   localparam int CPB = 16;
   localparam int TMO = 400;

   typedef struct {
      bit          is_err;
      logic [7:0]  id;
      logic [15:0] data;
      logic [1:0]  code;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        serial_rx = 1'b1;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        cmd_valid;
   logic [7:0]  cmd_id;
   logic [15:0] cmd_data;
   logic        cmd_err;
   logic [1:0]  err_code;

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          last_bv = 0;
   logic [7:0]  held_id = 8'h00;
   logic [15:0] held_data = 16'h0000;
   logic [7:0]  bq[$];
   exp_t        cq[$];

   uart_rx_cmd_fsm #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO), .HEADER(8'hA5)) dut (
      .clk(clk), .reset(reset), .serial_rx(serial_rx),
      .byte_valid(byte_valid), .byte_data(byte_data),
      .cmd_valid(cmd_valid), .cmd_id(cmd_id), .cmd_data(cmd_data),
      .cmd_err(cmd_err), .err_code(err_code)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         if (byte_valid) begin
            if (bq.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL byte_unexpected: got byte_valid with data %0h, expected none (cycle %0d)", byte_data, cyc);
            end else begin
               logic [7:0] eb;
               eb = bq.pop_front();
               chk("byte_data", int'(byte_data), int'(eb));
            end
            last_bv = cyc;
         end
         if (cmd_valid && cmd_err) chk("valid_err_overlap", 1, 0);
         if (cmd_valid || cmd_err) begin
            if (cq.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL cmd_unexpected: got valid=%0d err=%0d, expected none (cycle %0d)", cmd_valid, cmd_err, cyc);
            end else begin
               exp_t e;
               e = cq.pop_front();
               chk("cmd_kind_err", int'(cmd_err), int'(e.is_err));
               if (!e.is_err) begin
                  held_id   = e.id;
                  held_data = e.data;
               end else begin
                  chk("err_code", int'(err_code), int'(e.code));
               end
               chk("cmd_id", int'(cmd_id), int'(held_id));
               chk("cmd_data", int'(cmd_data), int'(held_data));
               if (e.lat >= 0) chk("cmd_latency", cyc - last_bv, e.lat);
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit push, input logic stop);
      if (push) bq.push_back(b);
      serial_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         serial_rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      serial_rx = stop;
      repeat (CPB) @(negedge clk);
      serial_rx = 1'b1;
   endtask

   task automatic send_pkt(input logic [7:0] id, input logic [15:0] val, input logic [7:0] cs);
      send_byte(8'hA5, 1'b1, 1'b1);
      send_byte(id, 1'b1, 1'b1);
      send_byte(val[7:0], 1'b1, 1'b1);
      send_byte(val[15:8], 1'b1, 1'b1);
      send_byte(cs, 1'b1, 1'b1);
   endtask

   task automatic expect_cmd(input bit is_err, input logic [7:0] id, input logic [15:0] data,
                             input logic [1:0] code, input int lat);
      exp_t e;
      e.is_err = is_err; e.id = id; e.data = data; e.code = code; e.lat = lat;
      cq.push_back(e);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((cq.size() != 0 || bq.size() != 0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk(name, cq.size() + bq.size(), 0);
   endtask

   initial begin
      reset = 1'b0;
      serial_rx = 1'b1;
      repeat (10) @(negedge clk);
      chk("rst_byte_valid", int'(byte_valid), 0);
      chk("rst_byte_data", int'(byte_data), 0);
      chk("rst_cmd_valid", int'(cmd_valid), 0);
      chk("rst_cmd_id", int'(cmd_id), 0);
      chk("rst_cmd_data", int'(cmd_data), 0);
      chk("rst_cmd_err", int'(cmd_err), 0);
      chk("rst_err_code", int'(err_code), 0);
      reset = 1'b1;
      repeat (500) @(negedge clk);

      expect_cmd(1'b0, 8'h03, 16'h1234, 2'd0, 1);
      send_pkt(8'h03, 16'h1234, 8'h25);
      drain("drain_good");

      expect_cmd(1'b1, 8'h00, 16'h0000, 2'd1, 1);
      send_pkt(8'h03, 16'h1234, 8'h00);
      drain("drain_badchk");
      expect_cmd(1'b0, 8'h07, 16'hABCD, 2'd0, 1);
      send_pkt(8'h07, 16'hABCD, 8'h61);
      drain("drain_good2");

      expect_cmd(1'b1, 8'h00, 16'h0000, 2'd2, -1);
      send_byte(8'hA5, 1'b1, 1'b1);
      send_byte(8'h03, 1'b1, 1'b1);
      send_byte(8'h34, 1'b0, 1'b0);
      repeat (40) @(negedge clk);
      drain("drain_frame");
      chk("frame_err_code_held", int'(err_code), 2);
      expect_cmd(1'b0, 8'h03, 16'h1234, 2'd0, 1);
      send_pkt(8'h03, 16'h1234, 8'h25);
      drain("drain_after_frame");

      send_byte(8'h00, 1'b1, 1'b1);
      send_byte(8'hFF, 1'b1, 1'b1);
      expect_cmd(1'b1, 8'h00, 16'h0000, 2'd3, TMO);
      send_byte(8'hA5, 1'b1, 1'b1);
      send_byte(8'h03, 1'b1, 1'b1);
      repeat (500) @(negedge clk);
      drain("drain_timeout");

      serial_rx = 1'b0;
      repeat (3) @(negedge clk);
      serial_rx = 1'b1;
      repeat (60) @(negedge clk);

      expect_cmd(1'b0, 8'h03, 16'h1234, 2'd0, 1);
      expect_cmd(1'b0, 8'h07, 16'hABCD, 2'd0, 1);
      send_pkt(8'h03, 16'h1234, 8'h25);
      send_pkt(8'h07, 16'hABCD, 8'h61);
      drain("drain_b2b");
      repeat (50) @(negedge clk);
      chk("final_cmd_id", int'(cmd_id), 32'h07);
      chk("final_cmd_data", int'(cmd_data), 32'hABCD);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_rx_cmd_fsm.md
# uart_rx_cmd_fsm

Receive-side counterpart of the board's UART telemetry transmitter. It deserialises 8N1 frames from `serial_rx` and assembles them into 5-byte command packets carrying a parameter ID and a 16-bit value, for example PID gain updates. It presents each checksum-verified command to the controller as a one-cycle strobe and reports malformed packets separately. It sits between the board RX pin and the PID parameter registers, in the same 125 MHz domain as the transmitter.

## Interface
- `CLKS_PER_BIT`, default 1085: clock cycles per UART bit (125 MHz / 115200). Legal range 8..65535.
- `TIMEOUT_CLKS`, default 125000: maximum idle cycles allowed between bytes inside a packet (1 ms).
- `HEADER`, default 8'hA5: packet start byte.
- `clk`, input, 1: system clock.
- `reset`, input, 1: synchronous, active-low. `reset==0` on a rising edge resets all state.
- `serial_rx`, input, 1: asynchronous UART line; idles high.
- `byte_valid`, output, 1: one-cycle pulse when a byte is received with a good stop bit.
- `byte_data`, output, 8: last received byte; held between pulses.
- `cmd_valid`, output, 1: one-cycle pulse when a packet is accepted.
- `cmd_id`, output, 8: parameter ID of the last accepted packet; held.
- `cmd_data`, output, 16: value of the last accepted packet; held.
- `cmd_err`, output, 1: one-cycle pulse when a packet is aborted.
- `err_code`, output, 2: cause of the last abort, held. 1 = checksum, 2 = framing, 3 = timeout. 0 after reset.

## Operation
- **Input synchroniser:** `serial_rx` passes through a 2-flop synchroniser. All logic uses the synchronised bit `rx_s`.
- **Bit FSM states:** B_IDLE, B_START, B_DATA, B_STOP, B_BREAK.
- **B_IDLE:** on `rx_s==0`, go to B_START and clear the counter.
- **B_START:** count `(CLKS_PER_BIT-1)/2` cycles (start-bit mid-point), then sample. Low → B_DATA. High → B_IDLE (glitch rejected; no output).
- **B_DATA:** count `CLKS_PER_BIT` cycles and sample; repeat for 8 bits, LSB first, into a shift register. Then go to B_STOP.
- **B_STOP:** count `CLKS_PER_BIT` cycles and sample.
  - High: update `byte_data`, pulse `byte_valid`, go to B_IDLE.
  - Low: framing error. Discard the byte, raise internal `frame_err` for one cycle, go to B_BREAK.
- **B_BREAK:** wait for `rx_s==1`, then go to B_IDLE.
- **Packet FSM states:** P_HDR, P_ID, P_LO, P_HI, P_CHK. Each state advances on `byte_valid`.
- **P_HDR:** a byte equal to `HEADER` → P_ID. Any other byte is ignored; stay in P_HDR.
- **P_ID, P_LO, P_HI:** latch ID, low byte, high byte into staging registers.
- **P_CHK:** compare the byte with `ID ^ LO ^ HI`.
  - Equal: load `cmd_id` and `cmd_data = {HI,LO}`, pulse `cmd_valid`.
  - Not equal: pulse `cmd_err`, set `err_code=1`.
  - Either way, return to P_HDR.
- **Aborts:** each abort pulses `cmd_err`, sets `err_code`, and returns to P_HDR.
  - `frame_err` while not in P_HDR: `err_code=2`.
  - `frame_err` in P_HDR: silent.
  - Timeout, evaluated only when not in P_HDR: a 17-bit counter clears on every `byte_valid` and otherwise increments. Reaching `TIMEOUT_CLKS` aborts with `err_code=3`.
- **Failed packets:** `cmd_id` and `cmd_data` are never modified by a failed packet.
- **Back-to-back packets:** supported. A header byte arriving immediately after P_CHK starts a new packet.

## Timing
- **Reset values:** `byte_valid=0`, `byte_data=0`, `cmd_valid=0`, `cmd_id=0`, `cmd_data=0`, `cmd_err=0`, `err_code=0`. Both FSMs go to IDLE/P_HDR and all counters clear.
- **Reset mid-frame:** discards any partial byte or packet; no pulse is emitted.
- **Input latency:** 2 cycles for the synchroniser.
- **`byte_valid` timing:** asserts on the cycle after the stop-bit sample. That is nominally `2 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT + 1` cycles after the falling start edge reaches `serial_rx`.
- **`cmd_valid` / `cmd_err` (checksum):** asserts exactly 1 cycle after the `byte_valid` of the checksum byte. `cmd_id` and `cmd_data` are valid in the same cycle and remain stable afterwards.
- **`cmd_err` (framing):** 1 cycle after the stop-bit sample.
- **`cmd_err` (timeout):** the cycle after the counter reaches `TIMEOUT_CLKS`.
- **Simultaneous events:** `byte_valid` and timeout in the same cycle: the byte wins and the counter clears. `cmd_valid` and `cmd_err` are never high together.
- **Throughput:** 1 byte per 10 bit-times, continuous with zero idle between frames. A new start edge is accepted on the first cycle back in B_IDLE.

## Test plan
Use `CLKS_PER_BIT=16` and `TIMEOUT_CLKS=400` for the bench. The bench UART driver sends 8N1 frames.

- **Reset:** hold `reset=0` for 10 cycles with `serial_rx=1` → all outputs 0. Release → no pulses for 500 cycles.
- **Good packet:** send A5 03 34 12 25 → exactly one `cmd_valid`, 1 cycle after the 5th `byte_valid`, with `cmd_id=8'h03`, `cmd_data=16'h1234`. `cmd_err` stays 0.
- **Bad checksum:** send A5 03 34 12 00 → one `cmd_err` with `err_code=1`, no `cmd_valid`, and `cmd_id`/`cmd_data` unchanged. Then a good packet, A5 07 CD AB 61, → `cmd_id=8'h07`, `cmd_data=16'hABCD`.
- **Framing error mid-packet:** send A5 03, then a frame with stop bit 0, then a line-high idle → `cmd_err`, `err_code=2`. A following good packet is accepted.
- **Timeout:** send A5 03, then idle for 500 cycles → `cmd_err`, `err_code=3` exactly 400 cycles after the second `byte_valid`. Junk bytes 00 FF before A5 are ignored.
- **Glitch and back-to-back:** a 3-cycle low pulse on `serial_rx` → no `byte_valid`. Two good packets with zero inter-frame gap → two `cmd_valid` pulses with the correct values.
